// File: rtl/wb_pkg.sv
// Shared types for the Wishbone single-transaction master and its benches.
package wb_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_RMW   = 2'd2
    } wb_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_MOD  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } wb_master_state_t;

    typedef enum logic {
        RETURN_ACK = 1'b0,
        RETURN_ERR = 1'b1
    } ret_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Per-phase wait counter; expires once TIMEOUT_CYCLES stalled strobe cycles have elapsed.
module wb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/wb_master_single.sv
// Wishbone B4 classic master: one read, write or locked read-modify-write per command.
// Optional per-phase timeout is enabled with `define WB_MASTER_TIMEOUT_EN.
module wb_master_single
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int GRANULE        = 8,
    parameter int SEL_WIDTH      = DATA_WIDTH / GRANULE,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    input  logic [DATA_WIDTH-1:0] cmd_mask_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [SEL_WIDTH-1:0]  sel_o,
    output logic                  we_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    input  logic                  ack_i,
    input  logic                  err_i
);
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    wb_master_state_t      state_q;
    wb_op_t                op_q;
    logic [DATA_WIDTH-1:0] wdat_q;
    logic [DATA_WIDTH-1:0] mask_q;
    logic                  tmo_expired;

`ifdef WB_MASTER_TIMEOUT_EN
    // Entries into RD/WR only happen from IDLE or MOD, so clearing there restarts each phase.
    wb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  ((state_q == ST_IDLE) || (state_q == ST_MOD)),
        .enable_i (stb_o && !ack_i && !err_i),
        .expired_o(tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_READ;
            wdat_q        <= '0;
            mask_q        <= '0;
            cmd_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_dat_o     <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            adr_o         <= '0;
            dat_o         <= '0;
            sel_o         <= '0;
            we_o          <= 1'b0;
            cyc_o         <= 1'b0;
            stb_o         <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        op_q        <= wb_op_t'(cmd_op_i);
                        wdat_q      <= cmd_dat_i;
                        mask_q      <= cmd_mask_i;
                        adr_o       <= cmd_adr_i;
                        sel_o       <= cmd_sel_i;
                        cmd_ready_o <= 1'b0;
                        cyc_o       <= 1'b1;
                        stb_o       <= 1'b1;
                        if (wb_op_t'(cmd_op_i) == OP_WRITE) begin
                            we_o    <= 1'b1;
                            dat_o   <= cmd_dat_i;
                            state_q <= ST_WR;
                        end else begin
                            we_o    <= 1'b0;
                            state_q <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (err_i || (!ack_i && tmo_expired)) begin
                        cyc_o         <= 1'b0;
                        stb_o         <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_err_o     <= 1'b1;
                        rsp_timeout_o <= !err_i;
                        state_q       <= ST_RESP;
                    end else if (ack_i) begin
                        rsp_dat_o <= dat_i;
                        stb_o     <= 1'b0;
                        if (op_q == OP_RMW) begin
                            state_q <= ST_MOD;
                        end else begin
                            cyc_o         <= 1'b0;
                            rsp_valid_o   <= 1'b1;
                            rsp_err_o     <= 1'b0;
                            rsp_timeout_o <= 1'b0;
                            state_q       <= ST_RESP;
                        end
                    end
                end
                ST_MOD: begin
                    // cyc_o stays high here so the read and write phases form one locked cycle.
                    dat_o   <= (rsp_dat_o & ~mask_q) | (wdat_q & mask_q);
                    stb_o   <= 1'b1;
                    we_o    <= 1'b1;
                    state_q <= ST_WR;
                end
                ST_WR: begin
                    if (err_i || ack_i || tmo_expired) begin
                        cyc_o         <= 1'b0;
                        stb_o         <= 1'b0;
                        we_o          <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_err_o     <= err_i || !ack_i;
                        rsp_timeout_o <= !err_i && !ack_i;
                        state_q       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    we_o        <= 1'b0;
                    cmd_ready_o <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    cyc_o       <= 1'b0;
                    stb_o       <= 1'b0;
                    we_o        <= 1'b0;
                    cmd_ready_o <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_single.sv
// Scoreboard bench for wb_master_single with a small behavioural register slave.
module tb_wb_master_single;
    import wb_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i = '0;
    logic [15:0] cmd_adr_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic [31:0] cmd_dat_i = '0;
    logic [31:0] cmd_mask_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic [15:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic [3:0]  sel_o;
    logic        we_o;
    logic        cyc_o;
    logic        stb_o;
    logic        ack_i;
    logic        err_i;

    always #5 clk = ~clk;

    wb_master_single #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .GRANULE(8), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_dat_i(cmd_dat_i),
        .cmd_mask_i(cmd_mask_i),
        .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel_o), .we_o(we_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i), .err_i(err_i)
    );

    // Behavioural slave: 16 word registers, programmable wait states and error injection.
    bit [31:0] mem [16];
    int        wait_states = 0;
    int        wcnt = 0;
    bit        err_rd = 0;
    bit        err_all = 0;
    bit        never_ack = 0;

    assign dat_i = mem[adr_o[5:2]];
    assign ack_i = cyc_o && stb_o && (wcnt >= wait_states) && !never_ack;
    assign err_i = cyc_o && stb_o && (err_all || (err_rd && !we_o));

    always @(posedge clk) begin
        if (cyc_o && stb_o && !(ack_i || err_i)) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (ack_i && !err_i && we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_o[b]) mem[adr_o[5:2]][b*8 +: 8] <= dat_o[b*8 +: 8];
            end
        end
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          chk_dat;
        logic [31:0] dat;
        ret_t        ret;
        bit          tmo;
        int          acc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   rsp_cnt = 0;
    int   wr_stb_cnt = 0;
    bit   cyc_drop = 0;

    always @(negedge clk) begin
        if (rst_i) begin
            cyc_drop <= 0;
        end else begin
            if (stb_o && we_o) wr_stb_cnt <= wr_stb_cnt + 1;
            if (exp_q.size() > 0 && !rsp_valid_o && !cyc_o) cyc_drop <= 1;
            if (rsp_valid_o) begin
                rsp_cnt <= rsp_cnt + 1;
                $display("rsp: dat=%08h err=%0b tmo=%0b cycle=%0d", rsp_dat_o, rsp_err_o,
                         rsp_timeout_o, cyc_cnt);
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk_dat) chk("rsp_dat", rsp_dat_o, e.dat);
                    chk("rsp_err", rsp_err_o, (e.ret == RETURN_ERR));
                    chk("rsp_timeout", rsp_timeout_o, e.tmo);
                    chk("latency", cyc_cnt - e.acc + 1, e.lat);
                    chk("cyc_held", cyc_drop, 0);
                    cyc_drop <= 0;
                end
            end
        end
    end

    int last_acc = 0;

    task automatic issue(input wb_op_t op, input logic [15:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input logic [31:0] mask, input bit chk_dat,
                         input logic [31:0] exp_dat, input ret_t ret, input bit tmo,
                         input int lat);
        int   n = 0;
        exp_t x;
        @(negedge clk);
        while (!cmd_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready_o) chk("cmd_ready_wait", 0, 1);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_adr_i   = adr;
        cmd_sel_i   = sel;
        cmd_dat_i   = dat;
        cmd_mask_i  = mask;
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        x.chk_dat = chk_dat;
        x.dat     = exp_dat;
        x.ret     = ret;
        x.tmo     = tmo;
        x.acc     = cyc_cnt;
        x.lat     = lat;
        exp_q.push_back(x);
        last_acc = cyc_cnt;
        $display("cmd: op=%0d adr=%04h sel=%h dat=%08h mask=%08h cycle=%0d", op, adr, sel,
                 dat, mask, cyc_cnt);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(posedge clk);
        #2;
        while ((exp_q.size() != 0 || !cmd_ready_o) && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 200) chk("idle_bound", 0, 1);
    endtask

    int acc_a;
    int stb_before;
    int rsp_before;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cyc", cyc_o, 0);
        chk("rst_stb", stb_o, 0);
        chk("rst_we", we_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_err", {rsp_err_o, rsp_timeout_o}, 0);
        chk("rst_bus", {adr_o, dat_o, sel_o}, 0);
        chk("rst_rsp_dat", rsp_dat_o, 0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_ready", cmd_ready_o, 1);

        // Plain write then read-back of a full word.
        issue(OP_WRITE, 16'h0004, 4'hF, 32'hDEADBEEF, '0, 0, '0, RETURN_ACK, 0, 2);
        issue(OP_READ, 16'h0004, 4'hF, '0, '0, 1, 32'hDEADBEEF, RETURN_ACK, 0, 2);
        wait_idle();

        // Partial-lane write.
        issue(OP_WRITE, 16'h0008, 4'h3, 32'h12345678, '0, 0, '0, RETURN_ACK, 0, 2);
        issue(OP_READ, 16'h0008, 4'hF, '0, '0, 1, 32'h00005678, RETURN_ACK, 0, 2);
        wait_idle();

        // Locked read-modify-write.
        issue(OP_WRITE, 16'h0004, 4'hF, 32'hFFFF0000, '0, 0, '0, RETURN_ACK, 0, 2);
        issue(OP_RMW, 16'h0004, 4'hF, 32'h000000AA, 32'h000000FF, 1, 32'hFFFF0000,
              RETURN_ACK, 0, 4);
        issue(OP_READ, 16'h0004, 4'hF, '0, '0, 1, 32'hFFFF00AA, RETURN_ACK, 0, 2);
        wait_idle();

        // Back-to-back issue interval.
        issue(OP_READ, 16'h0008, 4'hF, '0, '0, 1, 32'h00005678, RETURN_ACK, 0, 2);
        acc_a = last_acc;
        issue(OP_READ, 16'h0004, 4'hF, '0, '0, 1, 32'hFFFF00AA, RETURN_ACK, 0, 2);
        chk("issue_interval", last_acc - acc_a, 3);
        wait_idle();

        // Wait states stretch both plain and RMW transactions.
        wait_states = 2;
        issue(OP_READ, 16'h0008, 4'hF, '0, '0, 1, 32'h00005678, RETURN_ACK, 0, 4);
        issue(OP_RMW, 16'h0008, 4'h3, 32'h0000FF00, 32'h0000FF00, 1, 32'h00005678,
              RETURN_ACK, 0, 8);
        issue(OP_READ, 16'h0008, 4'hF, '0, '0, 1, 32'h0000FF78, RETURN_ACK, 0, 4);
        wait_idle();
        wait_states = 0;

        // ERR on the RMW read phase: no write strobe, old rsp_dat held.
        err_rd = 1;
        stb_before = wr_stb_cnt;
        issue(OP_RMW, 16'h0004, 4'hF, 32'h11111111, 32'hFFFFFFFF, 1, 32'h0000FF78,
              RETURN_ERR, 0, 2);
        wait_idle();
        chk("rmw_err_no_write", wr_stb_cnt - stb_before, 0);
        err_rd = 0;
        issue(OP_READ, 16'h0004, 4'hF, '0, '0, 1, 32'hFFFF00AA, RETURN_ACK, 0, 2);
        wait_idle();

        // ACK and ERR together: ERR wins.
        err_all = 1;
        issue(OP_WRITE, 16'h000C, 4'hF, 32'hCAFEF00D, '0, 0, '0, RETURN_ERR, 0, 2);
        wait_idle();
        err_all = 0;

`ifdef WB_MASTER_TIMEOUT_EN
        never_ack = 1;
        issue(OP_READ, 16'h0004, 4'hF, '0, '0, 0, '0, RETURN_ERR, 1, TMO + 2);
        wait_idle();
        never_ack = 0;
`endif

        // Reset in the middle of a stalled write phase.
        wait_states = 5;
        issue(OP_WRITE, 16'h0010, 4'hF, 32'h0BADC0DE, '0, 0, '0, RETURN_ACK, 0, 7);
        @(negedge clk);
        chk("in_wr_phase", {cyc_o, stb_o, we_o}, 3'b111);
        rsp_before = rsp_cnt;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_cyc", cyc_o, 0);
        chk("rst_mid_stb", stb_o, 0);
        exp_q.delete();
        @(negedge clk);
        rst_i = 1'b0;
        wait_states = 0;
        repeat (6) @(negedge clk);
        chk("rst_mid_no_rsp", rsp_cnt - rsp_before, 0);
        chk("rst_mid_ready", cmd_ready_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "simulation time limit");
    end

endmodule
